// File: rtl/proc_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for the parametrised core.
package proc_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_JR  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_e;

  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU for opcodes ADD..SHR; other opcodes yield zero result and carry.
module proc_alu
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  // Result and carry/borrow per opcode; C is cleared for the logic ops.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      // Extra top bit of the widened difference is the borrow.
      OP_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        carry  = a[DATA_W-1];
        result = {a[DATA_W-2:0], 1'b0};
      end
      OP_SHR: begin
        carry  = a[0];
        result = {1'b0, a[DATA_W-1:1]};
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/processor_param.sv
// Width-generic accumulator core: fetch handshake, IR, PC, accumulator, flags, register file.
module processor_param
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned RADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 CLB,
  input  logic [RADDR_W+3:0]   inst,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  output logic [ADDR_W-1:0]    pc,
  output logic [DATA_W-1:0]    acc,
  output logic [1:0]           flags,
  output logic                 halted
);

  localparam int unsigned NumRegs = 2 ** RADDR_W;
  // Overlapping widths for zero-extension / truncation of immediates and JR targets.
  localparam int unsigned ImmDW = (RADDR_W < DATA_W) ? RADDR_W : DATA_W;
  localparam int unsigned ImmAW = (RADDR_W < ADDR_W) ? RADDR_W : ADDR_W;
  localparam int unsigned JrW   = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;

  state_e               state_q, state_d;
  logic [RADDR_W+3:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [1:0]           flags_q, flags_d;
  logic [DATA_W-1:0]    regs_q [NumRegs];
  logic                 reg_we;

  logic [3:0]           opcode;
  logic [RADDR_W-1:0]   n;
  logic [DATA_W-1:0]    rdata;
  logic [DATA_W-1:0]    imm_data;
  logic [ADDR_W-1:0]    imm_addr;
  logic [ADDR_W-1:0]    jr_target;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_carry;
  logic                 alu_zero;

  assign opcode    = ir_q[RADDR_W+3 -: 4];
  assign n         = ir_q[RADDR_W-1:0];
  assign rdata     = regs_q[n];
  assign imm_data  = DATA_W'(n[ImmDW-1:0]);
  assign imm_addr  = ADDR_W'(n[ImmAW-1:0]);
  assign jr_target = ADDR_W'(rdata[JrW-1:0]);

  proc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (acc_q),
    .b      (rdata),
    .opcode (opcode),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept on valid, execute once, HALT is absorbing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (inst_valid) state_d = EXEC;
      EXEC:    state_d = (opcode == OP_HLT) ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // FSM outputs decoded straight from state.
  always_comb begin
    inst_ready = (state_q == FETCH);
    halted     = (state_q == HALT);
  end

  // Datapath next state: IR latches on accept, everything else changes only in EXEC.
  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    reg_we  = 1'b0;
    if (state_q == FETCH && inst_valid) begin
      ir_d = inst;
    end
    if (state_q == EXEC) begin
      pc_d = pc_q + ADDR_W'(1);
      case (opcode)
        OP_LDI: acc_d = imm_data;
        OP_LDR: acc_d = rdata;
        OP_STR: reg_we = 1'b1;
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
          acc_d           = alu_result;
          flags_d[FLAG_C] = alu_carry;
          flags_d[FLAG_Z] = alu_zero;
        end
        // Conditional jumps look only at the registered flags.
        OP_JMP: pc_d = imm_addr;
        OP_JZ:  if (flags_q[FLAG_Z]) pc_d = imm_addr;
        OP_JC:  if (flags_q[FLAG_C]) pc_d = imm_addr;
        OP_JR:  pc_d = jr_target;
        OP_HLT: pc_d = pc_q;
        default: ;
      endcase
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      ir_q    <= '0;
      pc_q    <= '0;
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  // Register file: single write port driven by STR.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[n] <= acc_q;
    end
  end

  assign pc    = pc_q;
  assign acc   = acc_q;
  assign flags = flags_q;

endmodule
